// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: in-order store buffer between the store unit and the
// data-memory write port, with optional per-lane store-to-load forwarding.
// Define DMEM_STB_FWD_EN to build the forwarding comparators; when it is
// undefined, fwd_be/fwd_data are tied to 0 and ld_addr is ignored.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [7:0]               in_be,
  input  logic [63:0]              in_data,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic [AW-1:0]            mem_wr_addr,
  output logic [7:0]               mem_wr_be,
  output logic [63:0]              mem_wr_data,
  input  logic [AW-1:0]            ld_addr,
  output logic [7:0]               fwd_be,
  output logic [63:0]              fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [7:0]    r_be   [DEPTH];
  logic [63:0]   r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_empty;

  assign w_empty      = (r_count == '0);
  assign empty        = w_empty;
  assign count        = r_count;
  assign in_ready     = (r_count != FULL);
  // Zero-lane requests are acknowledged but never occupy an entry.
  assign w_push       = in_valid && in_ready && (in_be != 8'h00);
  assign mem_wr_valid = !w_empty;
  assign w_pop        = mem_wr_valid && mem_wr_ready;

  assign mem_wr_addr  = w_empty ? '0 : r_addr[r_rptr];
  assign mem_wr_be    = w_empty ? '0 : r_be[r_rptr];
  assign mem_wr_data  = w_empty ? '0 : r_data[r_rptr];

  // Pointer, occupancy and per-entry valid bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_rptr        <= r_rptr + 1'b1;
        r_vld[r_rptr] <= 1'b0;
      end
      if (w_push) begin
        r_wptr        <= r_wptr + 1'b1;
        r_vld[r_wptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= in_addr;
      r_be[r_wptr]   <= in_be;
      r_data[r_wptr] <= in_data;
    end
  end

`ifdef DMEM_STB_FWD_EN
  logic [7:0]    w_fwd_be;
  logic [63:0]   w_fwd_data;
  logic [PW-1:0] w_idx;

  // Walk entries oldest to youngest so younger matching lanes overwrite older ones.
  // The entry popping this cycle is still valid here; this cycle's push is not yet stored.
  always_comb begin
    w_fwd_be   = '0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if (r_vld[w_idx] && (r_addr[w_idx] == ld_addr)) begin
        for (int b = 0; b < 8; b++) begin
          if (r_be[w_idx][b]) begin
            w_fwd_be[b]          = 1'b1;
            w_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign fwd_be   = w_fwd_be;
  assign fwd_data = w_fwd_data;
`else
  logic w_unused_fwd;

  assign fwd_be       = '0;
  assign fwd_data     = '0;
  assign w_unused_fwd = ^{ld_addr, r_vld};
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_be;
  logic [63:0]   in_data;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wr_be;
  logic [63:0]   mem_wr_data;
  logic [AW-1:0] ld_addr;
  logic [7:0]    fwd_be;
  logic [63:0]   fwd_data;
  logic [2:0]    count;
  logic          empty;

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int wr_snap;

  dmem_store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_be(in_be), .in_data(in_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_be(mem_wr_be), .mem_wr_data(mem_wr_data),
    .ld_addr(ld_addr), .fwd_be(fwd_be), .fwd_data(fwd_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Log a memory write if one fires at the coming edge, then settle 1ns past it.
  task automatic tick();
    if (!rst && mem_wr_valid && mem_wr_ready) n_wr++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_addr = '0; in_be = '0; in_data = '0;
    mem_wr_ready = 0; ld_addr = '0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_wr_valid", 64'(mem_wr_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_fwd_be", 64'(fwd_be), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single push, no bypass
    in_valid = 1; in_addr = 8'h05; in_be = 8'h0F; in_data = 64'h0000_0000_DEAD_BEEF;
    #1;
    chk("nobypass_valid", 64'(mem_wr_valid), 0);
    tick();
    in_valid = 0;
    chk("push1_valid", 64'(mem_wr_valid), 1);
    chk("push1_addr", 64'(mem_wr_addr), 64'h05);
    chk("push1_be", 64'(mem_wr_be), 64'h0F);
    chk("push1_data", mem_wr_data, 64'h0000_0000_DEAD_BEEF);
    chk("push1_count", 64'(count), 1);

    // fill to 4, fifth request refused
    for (int k = 6; k <= 8; k++) begin
      in_valid = 1; in_addr = 8'(k); in_be = 8'hFF; in_data = 64'h1111_0000_0000_0000 + 64'(k);
      tick();
    end
    in_valid = 0;
    chk("full_count", 64'(count), 4);
    chk("full_in_ready", 64'(in_ready), 0);
    in_valid = 1; in_addr = 8'h09; in_be = 8'hFF; in_data = 64'h9;
    tick();
    in_valid = 0;
    chk("fifth_count", 64'(count), 4);
    chk("stall_hold_addr", 64'(mem_wr_addr), 64'h05);
    chk("stall_hold_data", mem_wr_data, 64'h0000_0000_DEAD_BEEF);
    chk("stall_no_write", 64'(n_wr), 0);

    mem_wr_ready = 1;
    chk("drain0_addr", 64'(mem_wr_addr), 64'h05);
    tick();
    for (int k = 6; k <= 8; k++) begin
      chk("drain_addr", 64'(mem_wr_addr), 64'(k));
      chk("drain_data", mem_wr_data, 64'h1111_0000_0000_0000 + 64'(k));
      tick();
    end
    chk("drain_empty", 64'(empty), 1);
    chk("drain_writes", 64'(n_wr), 4);
    chk("empty_addr0", 64'(mem_wr_addr), 0);
    chk("empty_be0", 64'(mem_wr_be), 0);
    chk("empty_data0", mem_wr_data, 0);

    // zero-lane request
    in_valid = 1; in_addr = 8'h33; in_be = 8'h00; in_data = 64'hFFFF;
    #1;
    chk("be0_in_ready", 64'(in_ready), 1);
    tick();
    in_valid = 0;
    chk("be0_count", 64'(count), 0);
    chk("be0_no_valid", 64'(mem_wr_valid), 0);
    tick();
    chk("be0_no_write", 64'(n_wr), 4);

    // steady push+pop at count=2, pointers wrap several times
    mem_wr_ready = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_addr = 8'hA0 + 8'(k); in_be = 8'hFF; in_data = 64'(k);
      tick();
    end
    chk("pp_pre_count", 64'(count), 2);
    mem_wr_ready = 1;
    for (int k = 2; k < 12; k++) begin
      in_valid = 1; in_addr = 8'hA0 + 8'(k); in_be = 8'hFF; in_data = 64'(k);
      chk("pp_head", 64'(mem_wr_addr), 64'(8'hA0 + 8'(k - 2)));
      tick();
      chk("pp_count", 64'(count), 2);
    end
    in_valid = 0;
    chk("pp_tail0", 64'(mem_wr_addr), 64'hAA);
    chk("pp_tail0_data", mem_wr_data, 64'd10);
    tick();
    chk("pp_tail1", 64'(mem_wr_addr), 64'hAB);
    tick();
    chk("pp_empty", 64'(empty), 1);
    chk("pp_writes", 64'(n_wr), 16);

    // forwarding
    mem_wr_ready = 0;
    in_valid = 1; in_addr = 8'h10; in_be = 8'h03; in_data = 64'h0000_0000_0000_AAAA; tick();
    in_addr = 8'h10; in_be = 8'h01; in_data = 64'h0000_0000_0000_00BB; tick();
    in_addr = 8'h11; in_be = 8'hFF; in_data = 64'h0123_4567_89AB_CDEF; tick();
    in_valid = 0;
    ld_addr = 8'h10;
    #1;
`ifdef DMEM_STB_FWD_EN
    chk("fwd_be", 64'(fwd_be), 64'h03);
    chk("fwd_data", fwd_data, 64'h0000_0000_0000_AABB);
    mem_wr_ready = 1;
    #1;
    chk("fwd_pop_be", 64'(fwd_be), 64'h03);
    chk("fwd_pop_data", fwd_data, 64'h0000_0000_0000_AABB);
    mem_wr_ready = 0;
    in_valid = 1; in_addr = 8'h10; in_be = 8'hF0; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("fwd_nopush_be", 64'(fwd_be), 64'h03);
    in_valid = 0;
    ld_addr = 8'h11;
    #1;
    chk("fwd_11_be", 64'(fwd_be), 64'hFF);
    chk("fwd_11_data", fwd_data, 64'h0123_4567_89AB_CDEF);
    ld_addr = 8'h12;
    #1;
    chk("fwd_miss_be", 64'(fwd_be), 0);
    chk("fwd_miss_data", fwd_data, 0);
`else
    chk("nofwd_be", 64'(fwd_be), 0);
    chk("nofwd_data", fwd_data, 0);
    ld_addr = 8'h11;
    #1;
    chk("nofwd_11_be", 64'(fwd_be), 0);
`endif
    chk("fwd_count", 64'(count), 3);

    // mid-operation reset with 3 pending
    mem_wr_ready = 1;
    wr_snap = n_wr;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_wr_valid", 64'(mem_wr_valid), 0);
    chk("mrst_count", 64'(count), 0);
    chk("mrst_empty", 64'(empty), 1);
    chk("mrst_in_ready", 64'(in_ready), 1);
    chk("mrst_fwd_be", 64'(fwd_be), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("mrst_no_write", 64'(n_wr), 64'(wr_snap));
    chk("mrst_still_empty", 64'(mem_wr_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_store_buffer.md
DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered store entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 8, meaning the doubleword index width of the data memory.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset; clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  store request from the store unit.
REQ-006 in_ready  output  1  buffer can accept a request.
REQ-007 in_addr  input  AW  doubleword index.
REQ-008 in_be  input  8  byte-lane write enables.
REQ-009 in_data  input  64  lane-aligned store data.
REQ-010 mem_wr_valid  output  1  head entry presented to the memory write port.
REQ-011 mem_wr_ready  input  1  memory accepts the write this cycle.
REQ-012 mem_wr_addr, mem_wr_be, mem_wr_data  output  AW/8/64  head entry fields.
REQ-013 ld_addr  input  AW  load doubleword index for forwarding lookup.
REQ-014 fwd_be  output  8  lanes supplied by the buffer.
REQ-015 fwd_data  output  64  forwarded bytes; lanes with fwd_be=0 read 0.
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries; empty  output  1  count==0.

Function
REQ-017 The block SHALL be an in-order FIFO with wrap-around read and write pointers of $clog2(DEPTH) bits.
REQ-018 in_ready SHALL equal (count != DEPTH); a push in the same cycle as a pop SHALL NOT be accepted while full.
REQ-019 A push SHALL occur on a rising edge with in_valid && in_ready && (in_be != 0).
REQ-020 A request with in_be == 0 SHALL be acknowledged (in_ready high) and discarded without changing count.
REQ-021 mem_wr_valid SHALL equal !empty, and mem_wr_addr/be/data SHALL be driven combinationally from the head entry.
REQ-022 mem_wr_addr/be/data SHALL read 0 when empty.
REQ-023 A pop SHALL occur on a rising edge with mem_wr_valid && mem_wr_ready.
REQ-024 mem_wr_* SHALL hold stable while mem_wr_valid && !mem_wr_ready.
REQ-025 An entry pushed at edge N into an empty buffer SHALL appear on mem_wr_valid in the cycle following edge N; there is no combinational bypass.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0.
REQ-028 Forwarding SHALL be combinational, per byte lane: the youngest valid entry with addr == ld_addr and be[lane] set supplies that lane.
REQ-029 An entry being popped in the current cycle SHALL still participate in forwarding.
REQ-030 A push in the current cycle SHALL NOT participate in forwarding.

Reset
REQ-031 While rst is high, asynchronously: pointers = 0, count = 0, empty = 1, mem_wr_valid = 0, in_ready = 1, fwd_be = 0.
REQ-032 Entry storage need not be cleared on reset; all entry valid state SHALL be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all pending stores, with no memory write issued after rst rises.

Configuration
REQ-034 With macro DMEM_STB_FWD_EN defined, forwarding SHALL behave as described in REQ-028 to REQ-030.
REQ-035 With DMEM_STB_FWD_EN undefined, fwd_be and fwd_data SHALL be constant 0, no address comparators SHALL be instantiated, and ld_addr SHALL be ignored.

Verification
REQ-036 Reset, then push addr=0x05, be=0x0F, data=0x0000_0000_DEAD_BEEF with mem_wr_ready=0 -> next cycle mem_wr_valid=1, mem_wr_addr=0x05, mem_wr_be=0x0F, count=1.
REQ-037 Hold mem_wr_ready=0 and push 4 entries -> count=4, in_ready=0; a fifth request is not accepted; then mem_wr_ready=1 -> the 4 entries drain in push order over 4 cycles and empty=1.
REQ-038 Push be=0x00 -> in_ready=1, count unchanged, no memory write.
REQ-039 With count=2, push and pop in the same cycle -> count stays 2; the pointer wraps correctly after 10 such cycles.
REQ-040 FWD_EN: push (0x10, be=0x03, data=..AAAA) then (0x10, be=0x01, data=..BB), ld_addr=0x10 -> fwd_be=0x03, fwd_data[15:0]=0xAABB; without the macro -> fwd_be=0.
REQ-041 Assert rst with 3 entries pending -> mem_wr_valid=0 immediately, count=0, and no mem write occurs after rst is released.
